datapath_mc: RTL and testbench
==============================

// Module: datapath_mc
// PURPOSE
//  Parametrised register-file + ALU datapath for the FP square-root unit; successor of the fixed 8x32 datapath.
//  Adds generic width/depth, 3-bit ALU op set and a multi-cycle restoring unsigned divider with busy/done handshake.
//  Driven cycle-by-cycle by the sqrt controller FSM; registered data_o and N/Z flags feed back to it.
// PARAMETERS
//  DATA_WIDTH  32  register/ALU width in bits (>=4)
//  ADDR_WIDTH  3   register address width; register count = 2**ADDR_WIDTH
// PORTS
//  clk         in   1            rising-edge clock
//  rst_n       in   1            asynchronous active-low reset
//  IE          in   1            write source select: 1 = data_i, 0 = ALU result
//  WE          in   1            register-file write / op issue enable
//  OE          in   1            capture RF[ADDR_RDA] into data_o
//  ADDR_WR     in   ADDR_WIDTH   destination register
//  ADDR_RDA    in   ADDR_WIDTH   operand A / output read address
//  ADDR_RDB    in   ADDR_WIDTH   operand B address
//  ALU_Op      in   3            0 ADD,1 SUB,2 AND,3 OR,4 SHR1,5 SHL1,6 PASSA,7 DIV
//  data_i      in   DATA_WIDTH   external load data
//  data_o      out  DATA_WIDTH   registered read-out
//  negative_o  out  1            MSB of last ALU write-back
//  zero_o      out  1            last ALU write-back == 0
//  busy_o      out  1            divider running; issue blocked
//  done_o      out  1            one-cycle pulse: divide result written
// BEHAVIOUR
//  Reset (async, rst_n=0): all registers, data_o, flags, busy_o, done_o = 0; divider state cleared.
//  Reads of A/B combinational from RF; no hardwired-zero register.
//  When busy_o=0, at rising edge with WE=1:
//   - IE=1: RF[ADDR_WR] <= data_i; flags unchanged; ALU_Op ignored (IE wins over DIV).
//   - IE=0, ALU_Op 0-6: RF[ADDR_WR] <= result, single cycle; flags <= MSB/zero of result.
//     ADD/SUB modulo 2**DATA_WIDTH, carry dropped; SHR1 logical; SHL1 fills 0; op 6 passes A.
//   - IE=0, ALU_Op 7: launch edge E0 latches A (dividend), B (divisor), ADDR_WR; busy_o=1 after E0.
//  Divide: one quotient bit per edge E1..E_W (W=DATA_WIDTH), restoring, unsigned.
//   At E_W: RF[latched ADDR_WR] <= quotient, flags updated, busy_o->0, done_o=1 for exactly one cycle.
//   busy_o high exactly W cycles; next op may issue on the edge ending the done_o cycle.
//   Divisor 0: quotient = all ones, same W-cycle latency. Remainder discarded.
//  While busy_o=1: WE, IE, ALU_Op, ADDR_WR ignored (no RF write); reads and OE still operate.
//   Operand registers overwritten during divide do not affect it (values latched at E0).
//  OE: at edge with OE=1, data_o <= RF[ADDR_RDA] (pre-write value if same edge writes it); else hold.
//  WE=0: no RF or flag change. Flags hold between ALU write-backs.
//  Reset mid-divide: abort, no write-back, busy_o=0, done_o=0, RF cleared.
// TESTING (DATA_WIDTH=32, ADDR_WIDTH=3)
//  Reset release -> data_o=0, N=Z=0, busy=0, done=0; OE read of R0..R7 all return 0.
//  IE load R1=4, R2=3; ADD R3=R1+R2; OE R3 -> data_o=7, N=0, Z=0.
//  SUB R4=R2-R1 -> 0xFFFFFFFF, N=1; SUB R5=R1-R1 -> 0, Z=1; SHL1 of 0x80000000 -> 0, Z=1.
//  R1=100,R2=7, DIV R6 -> busy 32 cycles, done 1 pulse, R6=14; WE to R7 during busy leaves R7=0.
//  DIV 100/0 -> R6=0xFFFFFFFF, N=1 after 32 cycles; IE=1 with ALU_Op=7 loads data_i, busy stays 0.
//  Assert rst_n low at divide cycle 10 -> busy/done=0 immediately, dest reg reads 0, no done pulse.

Source files
------------

// File: rtl/datapath_mc.sv
// Register-file + ALU datapath for the FP square-root unit.
// Single-cycle ALU ops plus a multi-cycle restoring unsigned divider
// (one quotient bit per clock) with busy/done handshake toward the controller.
module datapath_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  IE,
  input  logic                  WE,
  input  logic                  OE,
  input  logic [ADDR_WIDTH-1:0] ADDR_WR,
  input  logic [ADDR_WIDTH-1:0] ADDR_RDA,
  input  logic [ADDR_WIDTH-1:0] ADDR_RDB,
  input  logic [2:0]            ALU_Op,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  negative_o,
  output logic                  zero_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_SHR1  = 3'd4;
  localparam logic [2:0] OP_SHL1  = 3'd5;
  localparam logic [2:0] OP_PASSA = 3'd6;
  localparam logic [2:0] OP_DIV   = 3'd7;

  logic [DATA_WIDTH-1:0] rf_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_r;
  logic                  negative_r;
  logic                  zero_r;
  logic                  busy_r;
  logic                  done_r;

  // Divider state: dvd_r shifts dividend bits out and quotient bits in.
  logic [DATA_WIDTH-1:0] dvd_r;
  logic [DATA_WIDTH-1:0] dvs_r;
  logic [DATA_WIDTH-1:0] rem_r;
  logic [ADDR_WIDTH-1:0] div_addr_r;
  logic [CNT_W-1:0]      cnt_r;

  logic [DATA_WIDTH-1:0] rd_a_s;
  logic [DATA_WIDTH-1:0] rd_b_s;
  logic [DATA_WIDTH-1:0] alu_res_s;
  logic [DATA_WIDTH:0]   rem_shift_s;
  logic [DATA_WIDTH:0]   trial_s;
  logic                  qbit_s;
  logic [DATA_WIDTH-1:0] rem_next_s;
  logic [DATA_WIDTH-1:0] quo_next_s;
  logic                  div_last_s;
  logic                  div_start_s;
  logic                  rf_we_s;
  logic [ADDR_WIDTH-1:0] rf_wa_s;
  logic [DATA_WIDTH-1:0] rf_wd_s;
  logic                  flag_we_s;

  assign rd_a_s = rf_r[ADDR_RDA];
  assign rd_b_s = rf_r[ADDR_RDB];

  // Single-cycle ALU result for ops 0-6; DIV is handled by the iterative unit.
  always_comb begin
    alu_res_s = '0;
    case (ALU_Op)
      OP_ADD:   alu_res_s = rd_a_s + rd_b_s;
      OP_SUB:   alu_res_s = rd_a_s - rd_b_s;
      OP_AND:   alu_res_s = rd_a_s & rd_b_s;
      OP_OR:    alu_res_s = rd_a_s | rd_b_s;
      OP_SHR1:  alu_res_s = {1'b0, rd_a_s[DATA_WIDTH-1:1]};
      OP_SHL1:  alu_res_s = {rd_a_s[DATA_WIDTH-2:0], 1'b0};
      OP_PASSA: alu_res_s = rd_a_s;
      default:  alu_res_s = rd_a_s;
    endcase
  end

  // One restoring step: shift in next dividend bit, try subtracting divisor.
  // A zero divisor always "fits", giving the all-ones quotient naturally.
  always_comb begin
    rem_shift_s = {rem_r, dvd_r[DATA_WIDTH-1]};
    trial_s     = rem_shift_s - {1'b0, dvs_r};
    qbit_s      = (dvs_r == '0) | ~trial_s[DATA_WIDTH];
    if (qbit_s) begin
      rem_next_s = trial_s[DATA_WIDTH-1:0];
    end else begin
      rem_next_s = rem_shift_s[DATA_WIDTH-1:0];
    end
    quo_next_s = {dvd_r[DATA_WIDTH-2:0], qbit_s};
    div_last_s = busy_r & (cnt_r == CNT_LAST);
  end

  // Write-port arbitration: divider write-back while busy, else WE/IE/ALU_Op issue.
  always_comb begin
    rf_we_s     = 1'b0;
    rf_wa_s     = ADDR_WR;
    rf_wd_s     = data_i;
    flag_we_s   = 1'b0;
    div_start_s = 1'b0;
    if (busy_r) begin
      if (div_last_s) begin
        rf_we_s   = 1'b1;
        rf_wa_s   = div_addr_r;
        rf_wd_s   = quo_next_s;
        flag_we_s = 1'b1;
      end else begin
        rf_we_s   = 1'b0;
      end
    end else if (WE) begin
      if (IE) begin
        rf_we_s = 1'b1;
      end else if (ALU_Op == OP_DIV) begin
        div_start_s = 1'b1;
      end else begin
        rf_we_s   = 1'b1;
        rf_wd_s   = alu_res_s;
        flag_we_s = 1'b1;
      end
    end else begin
      rf_we_s = 1'b0;
    end
  end

  // Register file storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_r[i] <= '0;
      end
    end else if (rf_we_s) begin
      rf_r[rf_wa_s] <= rf_wd_s;
    end
  end

  // Read-out register and N/Z flags of the last ALU/divide write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r     <= '0;
      negative_r <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      if (OE) begin
        data_r <= rd_a_s;
      end
      if (flag_we_s) begin
        negative_r <= rf_wd_s[DATA_WIDTH-1];
        zero_r     <= (rf_wd_s == '0);
      end
    end
  end

  // Divider sequencing: operands latched at launch, W iteration edges, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_r      <= '0;
      dvs_r      <= '0;
      rem_r      <= '0;
      div_addr_r <= '0;
      cnt_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= div_last_s;
      if (div_start_s) begin
        dvd_r      <= rd_a_s;
        dvs_r      <= rd_b_s;
        rem_r      <= '0;
        div_addr_r <= ADDR_WR;
        cnt_r      <= '0;
        busy_r     <= 1'b1;
      end else if (busy_r) begin
        dvd_r <= quo_next_s;
        rem_r <= rem_next_s;
        cnt_r <= cnt_r + CNT_W'(1);
        if (div_last_s) begin
          busy_r <= 1'b0;
        end
      end
    end
  end

  assign data_o     = data_r;
  assign negative_o = negative_r;
  assign zero_o     = zero_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;

endmodule

// File: tb/tb_datapath_mc.sv
// Self-checking bench for datapath_mc (DATA_WIDTH=32, ADDR_WIDTH=3).
// Table-driven single-cycle vectors through a scoreboard queue, plus
// hand-written divide, divide-by-zero and reset-mid-divide sequences.
module tb_datapath_mc;

  logic        clk;
  logic        rst_n;
  logic        ie, we, oe;
  logic [2:0]  wa, ra, rb, op;
  logic [31:0] din;
  logic [31:0] dout;
  logic        neg, zer, busy, done;

  int errors = 0;
  int checks = 0;

  datapath_mc #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .IE(ie), .WE(we), .OE(oe),
    .ADDR_WR(wa), .ADDR_RDA(ra), .ADDR_RDB(rb), .ALU_Op(op),
    .data_i(din), .data_o(dout), .negative_o(neg), .zero_o(zer),
    .busy_o(busy), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ie, we, oe;
    logic [2:0]  op, wa, ra, rb;
    logic [31:0] din;
    logic [31:0] exp_d;
    logic        exp_n, exp_z;
  } vec_t;

  vec_t vecs[17];
  vec_t sb_q[$];

  function automatic vec_t mk(logic i_ie, logic i_we, logic i_oe, logic [2:0] i_op,
                              logic [2:0] i_wa, logic [2:0] i_ra, logic [2:0] i_rb,
                              logic [31:0] i_din, logic [31:0] e_d, logic e_n, logic e_z);
    vec_t v;
    v.ie = i_ie; v.we = i_we; v.oe = i_oe; v.op = i_op;
    v.wa = i_wa; v.ra = i_ra; v.rb = i_rb; v.din = i_din;
    v.exp_d = e_d; v.exp_n = e_n; v.exp_z = e_z;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic i_ie, input logic i_we, input logic i_oe, input logic [2:0] i_op,
                       input logic [2:0] i_wa, input logic [2:0] i_ra, input logic [2:0] i_rb,
                       input logic [31:0] i_din);
    ie = i_ie; we = i_we; oe = i_oe; op = i_op;
    wa = i_wa; ra = i_ra; rb = i_rb; din = i_din;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 32'd0);
  endtask

  task automatic load(input logic [2:0] r, input logic [31:0] v);
    drive(1'b1, 1'b1, 1'b0, 3'd0, r, 3'd0, 3'd0, v);
    tick();
    idle();
  endtask

  task automatic read_reg(input logic [2:0] r, input string name, input logic [31:0] exp);
    drive(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, r, 3'd0, 32'd0);
    tick();
    idle();
    chk(name, dout, exp);
  endtask

  // Run a divide from its launch edge; return number of busy cycles seen.
  task automatic run_div(input logic [2:0] dst, input logic [2:0] a, input logic [2:0] b,
                         output int ncyc);
    drive(1'b0, 1'b1, 1'b0, 3'd7, dst, a, b, 32'd0);
    tick();
    // Attempted writes during busy must be ignored.
    drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd7, a, b, 32'hDEAD_BEEF);
    ncyc = 0;
    while (busy === 1'b1 && ncyc < 100) begin
      ncyc++;
      tick();
    end
    idle();
  endtask

  int ncyc;
  int done_seen;

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_data", dout, 32'd0);
    chk("reset_n", {31'd0, neg}, 32'd0);
    chk("reset_z", {31'd0, zer}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    for (int r = 0; r < 8; r++) begin
      read_reg(3'(r), "reset_rf", 32'd0);
    end

    vecs[0]  = mk(1, 1, 0, 3'd0, 3'd1, 3'd0, 3'd0, 32'd4,         32'd0,         0, 0);
    vecs[1]  = mk(1, 1, 0, 3'd0, 3'd2, 3'd0, 3'd0, 32'd3,         32'd0,         0, 0);
    vecs[2]  = mk(0, 1, 0, 3'd0, 3'd3, 3'd1, 3'd2, 32'd0,         32'd0,         0, 0);
    vecs[3]  = mk(0, 0, 1, 3'd0, 3'd0, 3'd3, 3'd0, 32'd0,         32'd7,         0, 0);
    vecs[4]  = mk(0, 1, 0, 3'd1, 3'd4, 3'd2, 3'd1, 32'd0,         32'd7,         1, 0);
    vecs[5]  = mk(0, 0, 1, 3'd0, 3'd0, 3'd4, 3'd0, 32'd0,         32'hFFFFFFFF, 1, 0);
    vecs[6]  = mk(0, 1, 0, 3'd1, 3'd5, 3'd1, 3'd1, 32'd0,         32'hFFFFFFFF, 0, 1);
    vecs[7]  = mk(1, 1, 0, 3'd0, 3'd6, 3'd0, 3'd0, 32'h80000000, 32'hFFFFFFFF, 0, 1);
    vecs[8]  = mk(0, 1, 0, 3'd3, 3'd7, 3'd6, 3'd1, 32'd0,         32'hFFFFFFFF, 1, 0);
    vecs[9]  = mk(0, 1, 0, 3'd5, 3'd7, 3'd6, 3'd0, 32'd0,         32'hFFFFFFFF, 0, 1);
    vecs[10] = mk(0, 1, 0, 3'd4, 3'd5, 3'd6, 3'd0, 32'd0,         32'hFFFFFFFF, 0, 0);
    vecs[11] = mk(1, 1, 1, 3'd0, 3'd5, 3'd5, 3'd0, 32'h12345678, 32'h40000000, 0, 0);
    vecs[12] = mk(0, 0, 1, 3'd0, 3'd0, 3'd5, 3'd0, 32'd0,         32'h12345678, 0, 0);
    vecs[13] = mk(0, 1, 0, 3'd2, 3'd0, 3'd5, 3'd6, 32'd0,         32'h12345678, 0, 1);
    vecs[14] = mk(0, 1, 0, 3'd6, 3'd0, 3'd6, 3'd0, 32'd0,         32'h12345678, 1, 0);
    vecs[15] = mk(0, 0, 1, 3'd0, 3'd0, 3'd0, 3'd0, 32'd0,         32'h80000000, 1, 0);
    vecs[16] = mk(0, 0, 1, 3'd1, 3'd4, 3'd7, 3'd0, 32'd0,         32'd0,         1, 0);

    for (int i = 0; i < 17; i++) begin
      vec_t e;
      drive(vecs[i].ie, vecs[i].we, vecs[i].oe, vecs[i].op,
            vecs[i].wa, vecs[i].ra, vecs[i].rb, vecs[i].din);
      sb_q.push_back(vecs[i]);
      tick();
      e = sb_q.pop_front();
      chk($sformatf("vec%0d_data", i), dout, e.exp_d);
      chk($sformatf("vec%0d_n", i), {31'd0, neg}, {31'd0, e.exp_n});
      chk($sformatf("vec%0d_z", i), {31'd0, zer}, {31'd0, e.exp_z});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
    end
    idle();

    // 100 / 7 into R6 with a blocked write to R7 during busy.
    load(3'd1, 32'd100);
    load(3'd2, 32'd7);
    run_div(3'd6, 3'd1, 3'd2, ncyc);
    chk("div_busy_cycles", 32'(ncyc), 32'd32);
    chk("div_done_pulse", {31'd0, done}, 32'd1);
    chk("div_n", {31'd0, neg}, 32'd0);
    chk("div_z", {31'd0, zer}, 32'd0);
    tick();
    chk("div_done_clear", {31'd0, done}, 32'd0);
    read_reg(3'd6, "div_quot", 32'd14);
    read_reg(3'd7, "div_blocked_wr", 32'd0);
    read_reg(3'd1, "div_blocked_ie", 32'd100);

    // Divide by zero.
    load(3'd2, 32'd0);
    run_div(3'd6, 3'd1, 3'd2, ncyc);
    chk("div0_busy_cycles", 32'(ncyc), 32'd32);
    chk("div0_done_pulse", {31'd0, done}, 32'd1);
    chk("div0_n", {31'd0, neg}, 32'd1);
    tick();
    read_reg(3'd6, "div0_quot", 32'hFFFFFFFF);

    // IE wins over DIV.
    drive(1'b1, 1'b1, 1'b0, 3'd7, 3'd3, 3'd1, 3'd2, 32'h00000ABC);
    tick();
    idle();
    chk("ie_div_busy", {31'd0, busy}, 32'd0);
    read_reg(3'd3, "ie_div_load", 32'h00000ABC);

    // Reset during divide cycle 10.
    load(3'd2, 32'd7);
    drive(1'b0, 1'b1, 1'b0, 3'd7, 3'd6, 3'd1, 3'd2, 32'd0);
    tick();
    idle();
    chk("rst_div_started", {31'd0, busy}, 32'd1);
    repeat (9) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    read_reg(3'd6, "rst_mid_dest", 32'd0);
    read_reg(3'd1, "rst_mid_rf", 32'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    chk("rst_mid_no_done", 32'(done_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
